// File: rtl/robo_pkg.sv
// robo_pkg: shared definitions for the maze navigation controller.
//   - state_t   : controller FSM encoding (3 bits)
//   - cmd_t     : command encodings driven toward the maze memory
//   - sensors_t : one-cycle snapshot of the four memory sensor outputs
//   - ORIENT_*  : robot orientation codes (N/E/S/W = 0..3); girar steps +1 mod 4
package robo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SENSE  = 3'd1,
    ST_DECIDE = 3'd2,
    ST_CMD    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_AVANCAR = 2'd1,
    CMD_GIRAR   = 2'd2,
    CMD_REMOVER = 2'd3
  } cmd_t;

  localparam logic [1:0] ORIENT_N = 2'd0;
  localparam logic [1:0] ORIENT_E = 2'd1;
  localparam logic [1:0] ORIENT_S = 2'd2;
  localparam logic [1:0] ORIENT_W = 2'd3;

  localparam int unsigned DEFAULT_SETTLE_CYCLES = 2;

  // A left turn is built from three clockwise quarter turns.
  localparam logic [1:0] LEFT_TURN_PULSES  = 2'd3;
  localparam logic [1:0] RIGHT_TURN_PULSES = 2'd1;

  typedef struct packed {
    logic head;
    logic left;
    logic under;
    logic barrier;
  } sensors_t;

endpackage

// File: rtl/robo_decisor.sv
// robo_decisor: combinational left-hand wall-following decision.
// Ports:
//   snap_i       sensor snapshot taken in SENSE
//   left_taken_i a left turn was the previous move (prevents turning left forever)
//   limit_hit_i  step counter has reached its maximum
//   cmd_o        command for this decision (CMD_NONE when finishing)
//   turns_o      number of girar pulses for this decision (3 = left, 1 = right)
//   done_o       navigation finished
//   timeout_o    finished because the step limit ran out
module robo_decisor
  import robo_pkg::*;
(
  input  sensors_t   snap_i,
  input  logic       left_taken_i,
  input  logic       limit_hit_i,
  output cmd_t       cmd_o,
  output logic [1:0] turns_o,
  output logic       done_o,
  output logic       timeout_o
);

  // First matching rule wins; exit check outranks the step limit.
  always_comb begin
    cmd_o     = CMD_NONE;
    turns_o   = 2'd0;
    done_o    = 1'b0;
    timeout_o = 1'b0;
    if (snap_i.under) begin
      done_o = 1'b1;
    end else if (limit_hit_i) begin
      done_o    = 1'b1;
      timeout_o = 1'b1;
    end else if (snap_i.head && snap_i.barrier) begin
      cmd_o = CMD_REMOVER;
    end else if (!snap_i.left && !left_taken_i) begin
      cmd_o   = CMD_GIRAR;
      turns_o = LEFT_TURN_PULSES;
    end else if (!snap_i.head) begin
      cmd_o = CMD_AVANCAR;
    end else begin
      cmd_o   = CMD_GIRAR;
      turns_o = RIGHT_TURN_PULSES;
    end
  end

endmodule

// File: rtl/robo_controlador.sv
// robo_controlador: navigation FSM driving the maze-memory block.
// Samples head/left/under/barrier once per decision (SENSE), decides
// (robo_decisor), issues one registered command pulse (CMD), then lets the
// memory settle for SETTLE_CYCLES (WAIT). Left turns repeat CMD/WAIT three times.
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   start                      begin navigation (honoured in IDLE and DONE only)
//   head_in/left_in/under_in/barrier_in  memory sensor outputs
//   avancar/girar/remover      one-cycle command pulses to the memory
//   busy, done, timeout        run status
//   step_count                 avancar pulses since start (saturates at MAX_STEPS)
//   cmd_count                  total command pulses, only with ROBO_CMD_COUNT_EN
// Build option: define ROBO_CMD_COUNT_EN to add the cmd_count output.
module robo_controlador
  import robo_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int unsigned MAX_STEPS     = 400,
  parameter int unsigned STEP_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              head_in,
  input  logic              left_in,
  input  logic              under_in,
  input  logic              barrier_in,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [STEP_W-1:0] step_count
`ifdef ROBO_CMD_COUNT_EN
  ,
  output logic [15:0]       cmd_count
`endif
);

  localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT  = STEP_W'(MAX_STEPS);

  state_t            state_q;
  sensors_t          snap_q;
  logic [3:0]        wait_q;
  logic [1:0]        turns_q;
  logic              left_taken_q;
  logic              avancar_q;
  logic              girar_q;
  logic              remover_q;
  logic              busy_q;
  logic              done_q;
  logic              timeout_q;
  logic [STEP_W-1:0] step_count_q;
  logic [STEP_W-1:0] step_count_d;
  logic              limit_hit_s;

  cmd_t              dec_cmd_s;
  logic [1:0]        dec_turns_s;
  logic              dec_done_s;
  logic              dec_timeout_s;

  assign limit_hit_s  = (step_count_q == STEP_LIMIT);
  // Saturating increment; the decision rules already stop at the limit.
  assign step_count_d = limit_hit_s ? step_count_q : step_count_q + STEP_W'(1);

  robo_decisor u_decisor (
    .snap_i       (snap_q),
    .left_taken_i (left_taken_q),
    .limit_hit_i  (limit_hit_s),
    .cmd_o        (dec_cmd_s),
    .turns_o      (dec_turns_s),
    .done_o       (dec_done_s),
    .timeout_o    (dec_timeout_s)
  );

  // Controller FSM with registered command pulses and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      snap_q       <= '0;
      wait_q       <= 4'd0;
      turns_q      <= 2'd0;
      left_taken_q <= 1'b0;
      avancar_q    <= 1'b0;
      girar_q      <= 1'b0;
      remover_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      step_count_q <= '0;
    end else begin
      // Pulses are high only in the single cycle spent in CMD.
      avancar_q <= 1'b0;
      girar_q   <= 1'b0;
      remover_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_SENSE;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            step_count_q <= '0;
            left_taken_q <= 1'b0;
          end
        end
        ST_SENSE: begin
          snap_q  <= '{head: head_in, left: left_in, under: under_in, barrier: barrier_in};
          state_q <= ST_DECIDE;
        end
        ST_DECIDE: begin
          if (dec_done_s) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= dec_timeout_s;
          end else begin
            state_q <= ST_CMD;
            wait_q  <= 4'd0;
            turns_q <= 2'd0;
            case (dec_cmd_s)
              CMD_AVANCAR: begin
                avancar_q    <= 1'b1;
                step_count_q <= step_count_d;
                left_taken_q <= 1'b0;
              end
              CMD_GIRAR: begin
                girar_q      <= 1'b1;
                turns_q      <= dec_turns_s - 2'd1;
                // The flag is only consulted at the next decision, so it can
                // be set as soon as the three-pulse left turn is committed.
                left_taken_q <= (dec_turns_s == LEFT_TURN_PULSES);
              end
              CMD_REMOVER: begin
                remover_q <= 1'b1;
              end
              default: begin
                state_q <= ST_SENSE;
              end
            endcase
          end
        end
        ST_CMD: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == SETTLE_LAST) begin
            wait_q <= 4'd0;
            if (turns_q != 2'd0) begin
              state_q <= ST_CMD;
              girar_q <= 1'b1;
              turns_q <= turns_q - 2'd1;
            end else begin
              state_q <= ST_SENSE;
            end
          end else begin
            wait_q <= wait_q + 4'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign avancar    = avancar_q;
  assign girar      = girar_q;
  assign remover    = remover_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign step_count = step_count_q;

`ifdef ROBO_CMD_COUNT_EN
  logic [15:0] cmd_count_q;
  logic        start_accept_s;

  assign start_accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Counts every pulse once: each pulse register is high for a single cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_count_q <= 16'd0;
    end else if (start_accept_s) begin
      cmd_count_q <= 16'd0;
    end else if ((avancar_q || girar_q || remover_q) && (cmd_count_q != 16'hFFFF)) begin
      cmd_count_q <= cmd_count_q + 16'd1;
    end
  end

  assign cmd_count = cmd_count_q;
`else
  // Command counter not built in this configuration.
`endif

endmodule

// File: tb/tb_robo_controlador.sv
module tb_robo_controlador;

  localparam int SETTLE = 2;
  localparam int MAXS   = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        head_in = 1'b0, left_in = 1'b1, under_in = 1'b0, barrier_in = 1'b0;
  logic        avancar, girar, remover, busy, done, timeout;
  logic [15:0] step_count;

  always #5 clock = ~clock;

  robo_controlador #(.SETTLE_CYCLES(SETTLE), .MAX_STEPS(MAXS), .STEP_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .head_in(head_in), .left_in(left_in), .under_in(under_in), .barrier_in(barrier_in),
    .avancar(avancar), .girar(girar), .remover(remover),
    .busy(busy), .done(done), .timeout(timeout), .step_count(step_count)
  );

  // kind: 0 avancar, 1 girar, 2 remover, 3 done
  typedef struct { int kind; int steps; int tmo; int gap; } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitor: pops expectations on every DUT event ----------
  int cyc = 0, last_ref = 0;
  bit done_prev = 1'b0, chk_start = 1'b0;
  int kind;
  exp_t e;

  always @(negedge clock) begin
    cyc++;
    if (chk_start) begin
      chk_start = 1'b0;
      chk("start_busy", int'(busy), 1);
      chk("start_done_clr", int'(done), 0);
      chk("start_tmo_clr", int'(timeout), 0);
      chk("start_steps_clr", int'(step_count), 0);
    end
    if (!reset && start && !busy) begin
      last_ref  = cyc;
      chk_start = 1'b1;
    end
    if (avancar || girar || remover) begin
      chk("onehot", int'(avancar) + int'(girar) + int'(remover), 1);
      kind = avancar ? 0 : (girar ? 1 : 2);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", kind, -1);
      end else begin
        e = sbq.pop_front();
        chk("cmd_kind", kind, e.kind);
        chk("cmd_steps", int'(step_count), e.steps);
        chk("cmd_gap", cyc - last_ref, e.gap);
      end
      last_ref = cyc;
    end
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 3, -1);
      end else begin
        e = sbq.pop_front();
        chk("done_kind", 3, e.kind);
        chk("done_timeout", int'(timeout), e.tmo);
        chk("done_steps", int'(step_count), e.steps);
        chk("done_gap", cyc - last_ref, e.gap);
        chk("done_busy", int'(busy), 0);
      end
      last_ref = cyc;
    end
    done_prev = done;
  end

  // ---------------- reference model (rule level) ---------------------------
  int m_steps;
  bit m_lt, m_first;

  task automatic push(input int k, input int s, input int t, input int g);
    exp_t x;
    x.kind = k; x.steps = s; x.tmo = t; x.gap = g;
    sbq.push_back(x);
  endtask

  task automatic model_decide(input logic h, input logic l, input logic u, input logic b,
                              output int n, output bit fin);
    int g;
    g = m_first ? 3 : SETTLE + 3;
    m_first = 1'b0;
    n = 1; fin = 1'b0;
    if (u) begin
      push(3, m_steps, 0, g); fin = 1'b1; n = 0;
    end else if (m_steps == MAXS) begin
      push(3, m_steps, 1, g); fin = 1'b1; n = 0;
    end else if (h && b) begin
      push(2, m_steps, 0, g);
    end else if (!l && !m_lt) begin
      push(1, m_steps, 0, g);
      push(1, m_steps, 0, SETTLE + 1);
      push(1, m_steps, 0, SETTLE + 1);
      m_lt = 1'b1; n = 3;
    end else if (!h) begin
      m_steps++; push(0, m_steps, 0, g); m_lt = 1'b0;
    end else begin
      push(1, m_steps, 0, g); m_lt = 1'b0;
    end
  endtask

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_pulses(input int n);
    int seen = 0;
    for (int c = 0; c < 60 && seen < n; c++) begin
      tick();
      if (avancar || girar || remover) seen++;
    end
    chk("wait_pulses", seen, n);
  endtask

  task automatic wait_done();
    for (int c = 0; c < 60 && !done; c++) tick();
    chk("wait_done", int'(done), 1);
  endtask

  // mode: 0 corridor, 1 left opening, 2 rubble, 3 dead end, 4 random, 5 endless corridor
  task automatic pick(input int mode, input int idx, input int maxd);
    head_in = 1'b0; left_in = 1'b1; barrier_in = 1'b0; under_in = (idx >= maxd);
    case (mode)
      1: left_in = 1'b0;
      2: if (idx == 0) begin head_in = 1'b1; barrier_in = 1'b1; end
      3: head_in = 1'b1;
      4: begin
        head_in = 1'($urandom % 2); left_in = 1'($urandom % 2);
        barrier_in = 1'($urandom % 2);
        under_in = (idx >= maxd) || ($urandom % 16 == 0);
      end
      5: under_in = 1'b0;
      default: ;
    endcase
  endtask

  task automatic run_session(input int mode, input int maxd);
    int n;
    bit fin;
    m_steps = 0; m_lt = 1'b0; m_first = 1'b1;
    pick(mode, 0, maxd);
    model_decide(head_in, left_in, under_in, barrier_in, n, fin);
    pulse_start();
    for (int idx = 1; idx < 60 && !fin; idx++) begin
      wait_pulses(n);
      // sensor noise (and an ignored start) while the memory settles
      head_in = 1'($urandom % 2); left_in = 1'($urandom % 2);
      under_in = 1'($urandom % 2); barrier_in = 1'($urandom % 2);
      start = ($urandom % 4 == 0);
      tick();
      start = 1'b0;
      under_in = 1'($urandom % 2);
      tick();
      pick(mode, idx, maxd);
      model_decide(head_in, left_in, under_in, barrier_in, n, fin);
    end
    wait_done();
    repeat (3) tick();
    chk("done_hold", int'(done), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_avancar"}, int'(avancar), 0);
    chk({tag, "_girar"}, int'(girar), 0);
    chk({tag, "_remover"}, int'(remover), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_steps"}, int'(step_count), 0);
  endtask

  // ---------------- main sequence ------------------------------------------
  initial begin
    int n;
    bit fin;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    run_session(0, 4);   // open corridor
    run_session(1, 3);   // left opening: left, avancar, left
    run_session(2, 2);   // rubble then forward
    run_session(3, 3);   // dead end
    run_session(5, 60);  // step limit -> timeout

    // reset in the middle of a left turn (after one avancar)
    m_steps = 0; m_lt = 1'b0; m_first = 1'b1;
    head_in = 1'b0; left_in = 1'b1; under_in = 1'b0; barrier_in = 1'b0;
    model_decide(head_in, left_in, under_in, barrier_in, n, fin);
    pulse_start();
    wait_pulses(1);
    left_in = 1'b0;
    model_decide(head_in, left_in, under_in, barrier_in, n, fin);
    wait_pulses(2);
    @(negedge clock); #1;
    sbq.delete();
    reset = 1'b1;
    tick();
    chk_all_zero("midturn_reset");
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("midturn_idle_busy", int'(busy), 0);

    run_session(0, 2);   // fresh start after reset
    for (int r = 0; r < 6; r++) run_session(4, 15);

    repeat (4) tick();
    chk("queue_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
